// File: rtl/fb_write_scheduler_if.sv
// Rasterizer pixel stream into the framebuffer write scheduler.
// Valid/ready handshake: a pixel moves when px_valid && px_ready.
interface fb_write_scheduler_if #(
    parameter int COLOR_W = 8
);
    logic               px_valid;
    logic               px_ready;
    logic [9:0]         px_x;
    logic [9:0]         px_y;
    logic [COLOR_W-1:0] px_color;

    modport master (
        output px_valid, px_x, px_y, px_color,
        input  px_ready
    );

    modport slave (
        input  px_valid, px_x, px_y, px_color,
        output px_ready
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// Owns framebuffer write port A: arbitrates a full-buffer clear
// engine against the rasterizer pixel stream, dropping off-screen pixels.
module fb_write_scheduler #(
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240,
    parameter int ADDR_W    = 17,
    parameter int COLOR_W   = 8
) (
    input  logic                aclk,
    input  logic                arstn,
    input  logic                clear_start,
    input  logic [COLOR_W-1:0]  clear_color,
    output logic                clear_busy,
    output logic                clear_done,
    fb_write_scheduler_if.slave px,
    output logic                fb_wea,
    output logic [ADDR_W-1:0]   fb_addra,
    output logic [COLOR_W-1:0]  fb_dina,
    output logic [15:0]         drop_count
);
    localparam logic [ADDR_W-1:0] LAST =
        ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic                 wea_q, wea_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [COLOR_W-1:0]   din_q, din_d;
    logic                 done_q, done_d;
    logic [15:0]          drop_q, drop_d;

    logic                 accept;
    logic                 on_screen;
    logic [ADDR_W-1:0]    px_addr;
    logic [ADDR_W-1:0]    cnt_nxt;

    assign px.px_ready = (state_q == IDLE) && !clear_start;
    assign accept      = px.px_valid && px.px_ready;
    assign on_screen   = (int'(px.px_x) < FB_WIDTH) &&
                         (int'(px.px_y) < FB_HEIGHT);
    assign px_addr     = ADDR_W'(px.px_y) * ADDR_W'(FB_WIDTH) +
                         ADDR_W'(px.px_x);
    assign cnt_nxt     = cnt_q + 1'b1;

    // cnt_q holds the address most recently written by the clear
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        wea_d   = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        done_d  = 1'b0;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    color_d = clear_color;
                    cnt_d   = '0;
                    wea_d   = 1'b1;
                    addr_d  = '0;
                    din_d   = clear_color;
                    done_d  = (LAST == '0);
                end else if (accept) begin
                    if (on_screen) begin
                        wea_d  = 1'b1;
                        addr_d = px_addr;
                        din_d  = px.px_color;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_nxt;
                    wea_d  = 1'b1;
                    addr_d = cnt_nxt;
                    din_d  = color_q;
                    done_d = (cnt_nxt == LAST);
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            wea_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            wea_q   <= wea_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign clear_busy = (state_q == CLEAR);
    assign clear_done = done_q;
    assign fb_wea     = wea_q;
    assign fb_addra   = addr_q;
    assign fb_dina    = din_q;
    assign drop_count = drop_q;
endmodule
